// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift sequencer and the
// downstream universal shift register it drives.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_SHL  = 2'b01,
    OP_SHR  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [1:0] SEL_HOLD = 2'(OP_HOLD);
  localparam logic [1:0] SEL_SHL  = 2'(OP_SHL);
  localparam logic [1:0] SEL_SHR  = 2'(OP_SHR);
  localparam logic [1:0] SEL_LOAD = 2'(OP_LOAD);

  function automatic logic is_shift(op_e op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/shift_sequencer.sv
// Command-driven sequencer producing sel / serial / parallel
// controls for a downstream universal shift register.
module shift_sequencer
  import shift_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_count,
  input  logic [7:0] cmd_bits,
  input  logic [3:0] cmd_load,
  input  logic       abort,
  output logic [1:0] sel,
  output logic       serial_in,
  output logic [3:0] par_out,
  output logic       busy,
  output logic       done
);

  state_e     r_state;
  op_e        r_op;
  logic [2:0] r_count;
  logic [7:0] r_bits;
  logic [2:0] r_idx;

  op_e        w_op;
  logic       w_last;
  logic [2:0] w_nidx;

  assign w_op      = op_e'(cmd_op);
  assign w_last    = (r_op == OP_LOAD) ||
                     (r_idx == r_count);
  assign w_nidx    = r_idx + 3'd1;
  assign cmd_ready = (r_state == ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_HOLD;
      r_count   <= '0;
      r_bits    <= '0;
      r_idx     <= '0;
      sel       <= SEL_HOLD;
      serial_in <= 1'b0;
      par_out   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (cmd_valid) begin
            r_op      <= w_op;
            r_count   <= cmd_count;
            r_bits    <= cmd_bits;
            r_idx     <= '0;
            r_state   <= ST_RUN;
            busy      <= 1'b1;
            sel       <= cmd_op;
            serial_in <= is_shift(w_op) & cmd_bits[0];
            if (w_op == OP_LOAD)
              par_out <= cmd_load;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_state   <= ST_IDLE;
            sel       <= SEL_HOLD;
            serial_in <= 1'b0;
            busy      <= 1'b0;
          end else if (w_last) begin
            r_state   <= ST_DONE;
            sel       <= SEL_HOLD;
            serial_in <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            r_idx     <= w_nidx;
            serial_in <= is_shift(r_op) & r_bits[w_nidx];
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          done    <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          sel       <= SEL_HOLD;
          serial_in <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed scoreboard bench for shift_sequencer with a
// behavioural downstream universal shift register.
module tb_shift_sequencer;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_count;
  logic [7:0] cmd_bits;
  logic [3:0] cmd_load;
  logic       abort;
  logic [1:0] sel;
  logic       serial_in;
  logic [3:0] par_out;
  logic       busy;
  logic       done;

  shift_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_count (cmd_count),
    .cmd_bits  (cmd_bits),
    .cmd_load  (cmd_load),
    .abort     (abort),
    .sel       (sel),
    .serial_in (serial_in),
    .par_out   (par_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // downstream register: 01 shift left, 10 shift right, 11 load
  logic [3:0] ds = 4'b0000;
  always @(posedge clk) begin
    case (sel)
      2'b01:   ds <= {ds[2:0], serial_in};
      2'b10:   ds <= {serial_in, ds[3:1]};
      2'b11:   ds <= par_out;
      default: ds <= ds;
    endcase
  end

  typedef struct packed {
    logic [1:0] e_sel;
    logic       e_si;
    logic [3:0] e_par;
    logic       e_busy;
    logic       e_done;
    logic       e_ready;
  } exp_t;

  exp_t       q[$];
  int         ncmp = 0;
  int         nfail = 0;
  logic [3:0] par_m = 4'b0000;

  task automatic check(string tag, logic [7:0] obs,
                       logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(logic [1:0] s, logic si, logic b,
                      logic d, logic r);
    exp_t e;
    e.e_sel   = s;
    e.e_si    = si;
    e.e_par   = par_m;
    e.e_busy  = b;
    e.e_done  = d;
    e.e_ready = r;
    q.push_back(e);
  endtask

  task automatic push_cmd(logic [1:0] op, logic [2:0] cnt,
                          logic [7:0] bits, logic [3:0] ld);
    if (op == 2'b11) begin
      par_m = ld;
      push(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    end else begin
      for (int i = 0; i <= int'(cnt); i++)
        push(op, (op == 2'b00) ? 1'b0 : bits[i],
             1'b1, 1'b0, 1'b0);
    end
    push(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    push(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic scramble();
    cmd_op    = 2'($urandom);
    cmd_count = 3'($urandom);
    cmd_bits  = 8'($urandom);
    cmd_load  = 4'($urandom);
  endtask

  task automatic issue(logic [1:0] op, logic [2:0] cnt,
                       logic [7:0] bits, logic [3:0] ld,
                       bit keep);
    cmd_op    = op;
    cmd_count = cnt;
    cmd_bits  = bits;
    cmd_load  = ld;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!keep) cmd_valid = 1'b0;
    scramble();
  endtask

  task automatic drain(int n, string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = q.pop_front();
      check($sformatf("%s c%0d sel", tag, i),
            8'(sel), 8'(e.e_sel));
      check($sformatf("%s c%0d serial", tag, i),
            8'(serial_in), 8'(e.e_si));
      check($sformatf("%s c%0d par", tag, i),
            8'(par_out), 8'(e.e_par));
      check($sformatf("%s c%0d busy", tag, i),
            8'(busy), 8'(e.e_busy));
      check($sformatf("%s c%0d done", tag, i),
            8'(done), 8'(e.e_done));
      check($sformatf("%s c%0d ready", tag, i),
            8'(cmd_ready), 8'(e.e_ready));
    end
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, " sel"},    8'(sel),       8'h00);
    check({tag, " serial"}, 8'(serial_in), 8'h00);
    check({tag, " par"},    8'(par_out),   8'h00);
    check({tag, " busy"},   8'(busy),      8'h00);
    check({tag, " done"},   8'(done),      8'h00);
    check({tag, " ready"},  8'(cmd_ready), 8'h01);
  endtask

  initial begin
    reset     = 1'b1;
    abort     = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_count = 3'd0;
    cmd_bits  = 8'hFF;
    cmd_load  = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("post_reset");

    push_cmd(2'b11, 3'd5, 8'h00, 4'b1010);
    issue(2'b11, 3'd5, 8'h00, 4'b1010, 1'b0);
    drain(3, "load1010");
    check("ds_load", 8'(ds), 8'h0A);

    push_cmd(2'b11, 3'd0, 8'h00, 4'b0000);
    issue(2'b11, 3'd0, 8'h00, 4'b0000, 1'b0);
    drain(3, "preload");
    check("ds_preload", 8'(ds), 8'h00);

    push_cmd(2'b01, 3'd3, 8'b0000_1011, 4'h0);
    issue(2'b01, 3'd3, 8'b0000_1011, 4'h0, 1'b0);
    drain(6, "shl4");
    check("ds_shl4", 8'(ds), 8'h0D);

    push_cmd(2'b10, 3'd7, 8'hA5, 4'h0);
    issue(2'b10, 3'd7, 8'hA5, 4'h0, 1'b0);
    drain(10, "shr8");
    check("ds_shr8", 8'(ds), 8'h0A);

    push_cmd(2'b00, 3'd2, 8'hFF, 4'h0);
    issue(2'b00, 3'd2, 8'hFF, 4'h0, 1'b0);
    drain(5, "hold3");
    check("ds_hold", 8'(ds), 8'h0A);

    push(2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    push(2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    push(2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    issue(2'b01, 3'd5, 8'h36, 4'h0, 1'b0);
    drain(3, "abort_run");
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    push(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    push(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    drain(2, "after_abort");

    push_cmd(2'b11, 3'd0, 8'h00, 4'b0110);
    issue(2'b11, 3'd0, 8'h00, 4'b0110, 1'b0);
    drain(2, "abort_done");
    abort = 1'b1;
    drain(1, "abort_done_idle");
    abort = 1'b0;
    check("ds_abort_done", 8'(ds), 8'h06);

    push_cmd(2'b11, 3'd0, 8'h00, 4'b1001);
    push_cmd(2'b01, 3'd1, 8'b0000_0010, 4'h0);
    issue(2'b11, 3'd0, 8'h00, 4'b1001, 1'b1);
    cmd_op    = 2'b01;
    cmd_count = 3'd1;
    cmd_bits  = 8'b0000_0010;
    cmd_load  = 4'h3;
    drain(3, "queued_a");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    scramble();
    drain(4, "queued_b");
    check("ds_queued", 8'(ds), 8'h05);

    push_cmd(2'b01, 3'd7, 8'hFF, 4'h0);
    issue(2'b01, 3'd7, 8'hFF, 4'h0, 1'b0);
    drain(4, "rst_mid");
    q.delete();
    reset = 1'b1;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    reset = 1'b0;
    par_m = 4'b0000;
    push(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    push(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    drain(2, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have exactly one clock, `clk  input  1`, rising-edge; all state updates on posedge clk.
REQ-002 `reset  input  1`: reset is asynchronous and active-high.
REQ-003 `cmd_valid  input  1`: a command is present on the cmd_* inputs.
REQ-004 `cmd_ready  output  1`: the sequencer can accept a command.
REQ-005 `cmd_op  input  2`: 00 = hold/wait, 01 = shift left, 10 = shift right, 11 = parallel load.
REQ-006 `cmd_count  input  3`: the number of active cycles is cmd_count+1 (1..8); it is ignored for load.
REQ-007 `cmd_bits  input  8`: serial bit pattern, consumed LSB first.
REQ-008 `cmd_load  input  4`: parallel value for the load op.
REQ-009 `abort  input  1`: synchronous cancel of the command in progress.
REQ-010 `sel  output  2`: mode select to the downstream universal shift register.
REQ-011 `serial_in  output  1`: serial bit to the downstream register.
REQ-012 `par_out  output  4`: parallel load value to the downstream register.
REQ-013 `busy  output  1`: a command is executing.
REQ-014 `done  output  1`: one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-016 cmd_ready SHALL be 1 in IDLE and only in IDLE; a command is accepted at the posedge where cmd_valid=1 and cmd_ready=1.
REQ-017 On accept, the block SHALL latch op, count, bits and load internally; cmd_* changes after accept SHALL have no effect.
REQ-018 sel, serial_in, par_out, busy and done SHALL be registered outputs, with no combinational path from inputs.
REQ-019 The first RUN cycle SHALL be the cycle immediately after accept; busy=1 throughout RUN.
REQ-020 Shift op, RUN cycle i (i = 0..count): sel=cmd_op, serial_in=bits[i].
REQ-021 Hold op: sel=00 for count+1 RUN cycles; serial_in=0.
REQ-022 Load op: exactly one RUN cycle with sel=11 and par_out=cmd_load, regardless of count.
REQ-023 After the last RUN cycle, the block SHALL enter DONE for one cycle: done=1, busy=0, sel=00; then return to IDLE.
REQ-024 In IDLE and DONE: sel=00, serial_in=0, and par_out holds its last value.
REQ-025 Back-to-back operation: minimum spacing is accept, RUN cycles, DONE, IDLE; a new accept is possible in the first IDLE cycle.
REQ-026 abort=1 sampled in RUN SHALL return the FSM to IDLE next cycle with sel=00 and busy=0, and SHALL suppress done.
REQ-027 abort in IDLE or DONE SHALL be ignored; a DONE pulse is never suppressed.
REQ-028 The internal bit index SHALL be 3 bits wide and SHALL terminate on equality with the latched count, with no wrap.

Reset
REQ-029 While reset=1: state=IDLE, sel=00, serial_in=0, par_out=0000, busy=0, done=0, bit index=0.
REQ-030 While reset=1, cmd_ready SHALL equal 1 (IDLE decode), but no command SHALL be accepted.
REQ-031 Reset asserted mid-RUN SHALL abandon the command immediately with no done pulse.

Structure
REQ-032 Op encodings (OP_HOLD, OP_SHL, OP_SHR, OP_LOAD) and state encodings SHALL be defined in the shared package shift_seq_pkg; the downstream register uses the same sel constants.
REQ-033 The block SHALL be a single module; no sub-module is warranted. Target size is 120-400 lines.

Verification
REQ-034 Reset, then cmd op=11, load=1010 → one cycle sel=11, par_out=1010; next cycle done=1; downstream out=1010.
REQ-035 Downstream preloaded to 0000, cmd op=01, count=3, bits=8'b0000_1011 → serial_in sequence 1,1,0,1 with sel=01 for 4 cycles; done on cycle 5; downstream out=1101.
REQ-036 cmd op=10, count=7, bits=8'hA5 → 8 RUN cycles with serial_in = 1,0,1,0,0,1,0,1; busy high for 8 cycles; one done pulse.
REQ-037 cmd op=01, count=5, abort asserted in RUN cycle 2 → sel=00 and busy=0 next cycle; no done; cmd_ready=1.
REQ-038 cmd_valid held high with two queued commands → second accepted in the first IDLE cycle after DONE; cmd_ready never 1 during RUN or DONE.
REQ-039 Async reset asserted mid-RUN (op=01, count=7, cycle 3) → all outputs at reset values before the next posedge; no done pulse.
